// File: rtl/accel_pkg.sv
// Shared widths and state type for the wide multiply/divide accelerators.
package accel_pkg;

  // Defaults match the 131x128 multiplier: A/QUOT_W, B/DIVISOR_W, P/DIVIDEND_W.
  localparam int unsigned AccelDividendW = 259;
  localparam int unsigned AccelDivisorW  = 128;
  localparam int unsigned AccelQuotW     = 131;
  localparam int unsigned AccelCntW      = $clog2(AccelDividendW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/accel_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, subtract.
module accel_div_step
  import accel_pkg::*;
#(
  parameter int unsigned DIVISOR_W = AccelDivisorW
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] d_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_bit_o
);

  localparam int unsigned AccW = DIVISOR_W + 1;

  logic [AccW:0] trial;
  logic [AccW:0] d_ext;

  // rem_i < d_i always holds, so its MSB is zero and the extra bit only guards the compare.
  always_comb begin
    trial   = {rem_i, bit_i};
    d_ext   = {2'b00, d_i};
    q_bit_o = (trial >= d_ext);
    rem_o   = q_bit_o ? AccW'(trial - d_ext) : AccW'(trial);
  end

endmodule

// File: rtl/accel_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
module accel_divider
  import accel_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = AccelDividendW,
  parameter int unsigned DIVISOR_W  = AccelDivisorW,
  parameter int unsigned QUOT_W     = AccelQuotW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] N,
  input  logic [DIVISOR_W-1:0]  D,
  output logic [QUOT_W-1:0]     Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  ready,
  output logic                  busy,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = $clog2(DIVIDEND_W + 1);

  div_state_t state_q, state_d;

  logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [QUOT_W-1:0]     q_q, q_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic                  ready_q, ready_d;
  logic                  ovf_q, ovf_d;
  logic                  dbz_q, dbz_d;

  logic [CntW-1:0]    bit_idx;
  logic               last_iter;
  logic               div_zero;
  logic [DIVISOR_W:0] step_rem;
  logic               step_qbit;

  // Iteration k consumes dividend bit DIVIDEND_W-1-k and fills the same quotient position.
  assign bit_idx   = CntW'(DIVIDEND_W - 1) - cnt_q;
  assign last_iter = (cnt_q == CntW'(DIVIDEND_W - 1));
  assign div_zero  = (divisor_q == '0);

  accel_div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (dividend_q[bit_idx]),
    .d_i    (divisor_q),
    .rem_o  (step_rem),
    .q_bit_o(step_qbit)
  );

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start accepted only when idle or done; start in BUSY is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = BUSY;
      BUSY:       if (div_zero || last_iter) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath next-state: operand capture, iteration, result latch.
  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    ready_d    = ready_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dividend_d = N;
          divisor_d  = D;
          rem_d      = '0;
          quo_d      = '0;
          cnt_d      = '0;
          ready_d    = 1'b0;
          ovf_d      = 1'b0;
          dbz_d      = 1'b0;
        end
      end
      BUSY: begin
        if (div_zero) begin
          // Divide by zero finishes after a single busy cycle.
          q_d     = '1;
          r_d     = '0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b1;
          ready_d = 1'b1;
        end else begin
          rem_d        = step_rem;
          quo_d[bit_idx] = step_qbit;
          cnt_d        = cnt_q + 1'b1;
          if (last_iter) begin
            q_d     = quo_d[QUOT_W-1:0];
            r_d     = DIVISOR_W'(step_rem);
            ovf_d   = |quo_d[DIVIDEND_W-1:QUOT_W];
            ready_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

  // Outputs come straight from registers; busy is decoded from state.
  always_comb begin
    Q           = q_q;
    R           = r_q;
    ready       = ready_q;
    busy        = (state_q == BUSY);
    overflow    = ovf_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_accel_divider.sv
// Self-checking bench for accel_divider: directed cases plus random round trips.
module tb_accel_divider;

  localparam int unsigned NW = 259;
  localparam int unsigned DW = 128;
  localparam int unsigned QW = 131;
  localparam int LAT = 259;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] N;
  logic [DW-1:0] D;
  logic [QW-1:0] Q;
  logic [DW-1:0] R;
  logic          ready;
  logic          busy;
  logic          overflow;
  logic          div_by_zero;

  int n_assert = 0;
  int n_fail   = 0;

  accel_divider dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .N          (N),
    .D          (D),
    .Q          (Q),
    .R          (R),
    .ready      (ready),
    .busy       (busy),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] rand_wide();
    logic [287:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[255:0], $urandom};
    return v;
  endfunction

  // Pulse start for one edge with the given operands; returns just after that edge.
  task automatic do_start(input logic [NW-1:0] n, input logic [DW-1:0] d);
    start = 1'b1;
    N     = n;
    D     = d;
    tick();
    start = 1'b0;
    N     = NW'(rand_wide());
    D     = DW'(rand_wide());
  endtask

  // Counts cycles until ready, bounded; also counts cycles where busy was not high.
  task automatic wait_done(output int cyc, output int busy_low);
    cyc      = 0;
    busy_low = 0;
    while (ready !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1) busy_low++;
      tick();
      cyc++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [QW-1:0] eq, input logic [DW-1:0] er,
                         input logic eo, input logic ez);
    chk({tag, " Q"}, 288'(Q), 288'(eq));
    chk({tag, " R"}, 288'(R), 288'(er));
    chk({tag, " overflow"}, 288'(overflow), 288'(eo));
    chk({tag, " div_by_zero"}, 288'(div_by_zero), 288'(ez));
    chk({tag, " ready"}, 288'(ready), 288'(1'b1));
    chk({tag, " busy_after"}, 288'(busy), 288'(1'b0));
  endtask

  // Reference: plain wide division, then split quotient into reported and overflow parts.
  task automatic chk_model(input string tag, input logic [NW-1:0] n, input logic [DW-1:0] d);
    logic [NW-1:0] qf;
    logic [NW-1:0] rm;
    qf = n / NW'(d);
    rm = n % NW'(d);
    chk_res(tag, qf[QW-1:0], rm[DW-1:0], |qf[NW-1:QW], 1'b0);
  endtask

  task automatic run_model(input string tag, input logic [NW-1:0] n, input logic [DW-1:0] d);
    int cyc;
    int bl;
    do_start(n, d);
    wait_done(cyc, bl);
    chk({tag, " latency"}, 288'(cyc), 288'(LAT));
    chk({tag, " busy_during"}, 288'(bl), 288'(0));
    chk_model(tag, n, d);
  endtask

  initial begin
    int            cyc;
    int            bl;
    int            seen;
    logic [QW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    logic [NW-1:0] n;

    // Reset with start asserted: start must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    N     = NW'(12345);
    D     = '0;
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    chk("rst Q", 288'(Q), 288'(0));
    chk("rst R", 288'(R), 288'(0));
    chk("rst ready", 288'(ready), 288'(0));
    chk("rst overflow", 288'(overflow), 288'(0));
    chk("rst div_by_zero", 288'(div_by_zero), 288'(0));
    tick();
    chk("rst busy", 288'(busy), 288'(0));

    // Basic 100 / 7.
    do_start(NW'(100), DW'(7));
    wait_done(cyc, bl);
    chk("basic latency", 288'(cyc), 288'(LAT));
    chk("basic busy_during", 288'(bl), 288'(0));
    chk_res("basic", QW'(14), DW'(2), 1'b0, 1'b0);
    repeat (5) tick();
    chk("basic hold Q", 288'(Q), 288'(14));
    chk("basic hold ready", 288'(ready), 288'(1));

    // Directed round trip.
    a = (QW'(1) << 130) + QW'(5);
    b = (DW'(1) << 127) + DW'(3);
    r = DW'(1) << 126;
    n = NW'(a) * NW'(b) + NW'(r);
    do_start(n, b);
    wait_done(cyc, bl);
    chk("rt latency", 288'(cyc), 288'(LAT));
    chk_res("rt", a, r, 1'b0, 1'b0);

    // Divide by zero: one busy cycle, then done.
    do_start(NW'(12345), DW'(0));
    chk("dbz busy", 288'(busy), 288'(1));
    chk("dbz ready_early", 288'(ready), 288'(0));
    tick();
    chk_res("dbz", '1, '0, 1'b0, 1'b1);

    // Overflow boundary.
    run_model("ovf", NW'(1) << 258, DW'(1));
    chk("ovf flag", 288'(overflow), 288'(1));
    chk("ovf Q", 288'(Q), 288'(0));
    run_model("maxq", NW'((QW'(1) << (QW - 1)) - QW'(1)) * NW'(2) + NW'(1), DW'(1));
    chk("maxq Q", 288'(Q), 288'({QW{1'b1}}));

    // Start during BUSY is ignored.
    do_start(NW'(100), DW'(7));
    repeat (49) tick();
    start = 1'b1;
    N     = NW'(9);
    D     = DW'(3);
    tick();
    start = 1'b0;
    D     = '0;
    wait_done(cyc, bl);
    chk("ign latency", 288'(cyc + 50), 288'(LAT));
    chk_res("ign", QW'(14), DW'(2), 1'b0, 1'b0);

    // Restart from DONE drops ready on the start edge.
    do_start(NW'(9), DW'(3));
    chk("restart ready_drop", 288'(ready), 288'(0));
    wait_done(cyc, bl);
    chk("restart latency", 288'(cyc), 288'(LAT));
    chk_res("restart", QW'(3), DW'(0), 1'b0, 1'b0);

    // Reset mid-operation abandons it.
    do_start(NW'(rand_wide()), DW'(rand_wide()) | DW'(1));
    repeat (119) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst Q", 288'(Q), 288'(0));
    chk("midrst R", 288'(R), 288'(0));
    chk("midrst ready", 288'(ready), 288'(0));
    chk("midrst busy", 288'(busy), 288'(0));
    chk("midrst overflow", 288'(overflow), 288'(0));
    chk("midrst div_by_zero", 288'(div_by_zero), 288'(0));
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (ready !== 1'b0 || busy !== 1'b0) seen++;
      tick();
    end
    chk("midrst quiet", 288'(seen), 288'(0));
    run_model("postrst", NW'(rand_wide()), DW'(rand_wide()) >> $urandom_range(0, 120));

    // Random round trips: N = A*B + r must give back A and r.
    for (int k = 0; k < 200; k++) begin
      a = QW'(rand_wide());
      b = DW'(rand_wide()) >> $urandom_range(0, 127);
      if (b == '0) b = DW'(1);
      r = DW'(rand_wide()) % b;
      n = NW'(a) * NW'(b) + NW'(r);
      do_start(n, b);
      wait_done(cyc, bl);
      chk("rand latency", 288'(cyc), 288'(LAT));
      chk("rand Q", 288'(Q), 288'(a));
      chk("rand R", 288'(R), 288'(r));
      chk("rand overflow", 288'(overflow), 288'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
